// File: rtl/hci_core_sink_simple_pkg.sv
// Shared types for the HCI core sink streamer: control/flag structs and FSM states.
package hci_core_sink_simple_pkg;

  localparam int HCI_ADDR_WIDTH = 32;
  localparam int HCI_CNT_WIDTH  = 16;

  typedef struct packed {
    logic                      req_start;
    logic [HCI_ADDR_WIDTH-1:0] base_addr;
    logic [HCI_ADDR_WIDTH-1:0] stride;
    logic [HCI_CNT_WIDTH-1:0]  tot_len;
  } hci_sink_simple_ctrl_t;

  typedef struct packed {
    logic                     ready_start;
    logic                     done;
    logic                     busy;
    logic [HCI_CNT_WIDTH-1:0] out_cnt;
  } hci_sink_simple_flags_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WORKING = 2'd1,
    DONE    = 2'd2
  } hci_streamer_state_t;

endpackage

// File: rtl/hci_core_sink_simple_if.sv
// TCDM master port bundle and HWPE-Stream bundle used by the sink streamer.
interface hci_core_intf #(
  parameter int DW = 32
) ();
  logic            req;
  logic            gnt;
  logic [31:0]     add;
  logic            wen;
  logic [DW/8-1:0] be;
  logic [DW-1:0]   data;
  logic [DW/8-1:0] boffs;
  logic            lrdy;
  logic            r_valid;
  logic [DW-1:0]   r_data;

  modport master (
    output req, add, wen, be, data, boffs, lrdy,
    input  gnt, r_valid, r_data
  );

  modport slave (
    input  req, add, wen, be, data, boffs, lrdy,
    output gnt, r_valid, r_data
  );
endinterface

interface hwpe_stream_intf_stream #(
  parameter int DW = 32
) ();
  logic            valid;
  logic            ready;
  logic [DW-1:0]   data;
  logic [DW/8-1:0] strb;

  modport source (
    output valid, data, strb,
    input  ready
  );

  modport sink (
    input  valid, data, strb,
    output ready
  );
endinterface

// File: rtl/hci_core_sink_simple_fifo.sv
// Small registered circular FIFO buffering {strb, data} beats between stream and TCDM.
module hci_core_sink_simple_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             test_mode_i,
  input  logic             i_push_valid,
  output logic             o_push_ready,
  input  logic [WIDTH-1:0] i_push_data,
  output logic             o_pop_valid,
  input  logic             i_pop_ready,
  output logic [WIDTH-1:0] o_pop_data
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;
  logic             w_unused;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign o_push_ready = (r_count != CW'(DEPTH));
  assign o_pop_valid  = (r_count != '0);
  assign w_push       = i_push_valid & o_push_ready;
  assign w_pop        = i_pop_ready & o_pop_valid;
  assign o_pop_data   = r_mem[r_rd_ptr];
  assign w_unused     = test_mode_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clear_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: r_count gates every read.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_data;
  end

endmodule

// File: rtl/hci_core_sink_simple.sv
// Sink streamer: buffers an HWPE-Stream and writes it out as strided TCDM stores.
//   state   | meaning
//   IDLE    | waiting for req_start, ready_start high
//   WORKING | accepting beats and issuing writes until tot_len grants
//   DONE    | single-cycle done pulse, then back to IDLE
module hci_core_sink_simple
  import hci_core_sink_simple_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   test_mode_i,
  input  logic                   clear_i,
  hci_core_intf.master           tcdm,
  hwpe_stream_intf_stream.sink   stream,
  input  hci_sink_simple_ctrl_t  ctrl_i,
  output hci_sink_simple_flags_t flags_o
);

  localparam int BW = DATA_WIDTH / 8;
  localparam int FW = DATA_WIDTH + BW;

  hci_streamer_state_t r_state;
  hci_streamer_state_t w_state_next;

  logic [31:0]          r_addr;
  logic [31:0]          r_stride;
  logic [CNT_WIDTH-1:0] r_tot_len;
  logic [CNT_WIDTH-1:0] r_in_cnt;
  logic [CNT_WIDTH-1:0] r_out_cnt;

  logic          w_start;
  logic          w_push;
  logic          w_grant;
  logic          w_last;
  logic          w_in_room;
  logic          w_fifo_ready;
  logic          w_fifo_valid;
  logic [FW-1:0] w_fifo_out;
  logic          w_unused;

  hci_core_sink_simple_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) i_fifo (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .clear_i      (clear_i),
    .test_mode_i  (test_mode_i),
    .i_push_valid (w_push),
    .o_push_ready (w_fifo_ready),
    .i_push_data  ({stream.strb, stream.data}),
    .o_pop_valid  (w_fifo_valid),
    .i_pop_ready  (w_grant),
    .o_pop_data   (w_fifo_out)
  );

  // Beats past tot_len are refused so the upstream keeps them.
  assign w_in_room    = (r_in_cnt < r_tot_len);
  assign stream.ready = (r_state == WORKING) & w_fifo_ready & w_in_room;
  assign w_push       = stream.valid & stream.ready;

  assign tcdm.req   = (r_state == WORKING) & w_fifo_valid;
  assign tcdm.add   = r_addr;
  assign tcdm.wen   = 1'b0;
  assign tcdm.data  = w_fifo_out[DATA_WIDTH-1:0];
  assign tcdm.be    = w_fifo_out[FW-1:DATA_WIDTH];
  assign tcdm.boffs = '0;
  assign tcdm.lrdy  = 1'b1;
  assign w_grant    = tcdm.req & tcdm.gnt;
  assign w_last     = (r_out_cnt == r_tot_len - CNT_WIDTH'(1));

  assign w_unused = ^{tcdm.r_valid, tcdm.r_data};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    flags_o      = '0;
    case (r_state)
      IDLE: begin
        flags_o.ready_start = 1'b1;
        if (ctrl_i.req_start && !clear_i) begin
          w_start      = 1'b1;
          w_state_next = (ctrl_i.tot_len == '0) ? DONE : WORKING;
        end
      end
      WORKING: begin
        if (w_grant && w_last) w_state_next = DONE;
      end
      DONE: begin
        flags_o.done = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
    if (clear_i) w_state_next = IDLE;
    flags_o.busy    = (r_state != IDLE);
    flags_o.out_cnt = HCI_CNT_WIDTH'(r_out_cnt);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_addr    <= '0;
      r_stride  <= '0;
      r_tot_len <= '0;
      r_in_cnt  <= '0;
      r_out_cnt <= '0;
    end else if (clear_i) begin
      r_addr    <= '0;
      r_stride  <= '0;
      r_tot_len <= '0;
      r_in_cnt  <= '0;
      r_out_cnt <= '0;
    end else if (w_start) begin
      r_addr    <= ctrl_i.base_addr;
      r_stride  <= ctrl_i.stride;
      r_tot_len <= CNT_WIDTH'(ctrl_i.tot_len);
      r_in_cnt  <= '0;
      r_out_cnt <= '0;
    end else begin
      if (w_push) r_in_cnt <= r_in_cnt + CNT_WIDTH'(1);
      // Address wraps modulo 2^32 by design; no alignment checking.
      if (w_grant) begin
        r_addr    <= r_addr + r_stride;
        r_out_cnt <= r_out_cnt + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_hci_core_sink_simple.sv
// Directed bench for hci_core_sink_simple: drives stream/grant per cycle and logs TCDM writes.
module tb_hci_core_sink_simple;
  import hci_core_sink_simple_pkg::*;

  localparam int DW = 32;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  logic test_mode_i = 1'b0;
  logic clear_i = 1'b0;
  hci_sink_simple_ctrl_t  ctrl_i;
  hci_sink_simple_flags_t flags_o;

  hci_core_intf #(.DW(DW)) tcdm ();
  hwpe_stream_intf_stream #(.DW(DW)) stream ();

  always #5 clk_i = ~clk_i;

  hci_core_sink_simple #(
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (2),
    .CNT_WIDTH  (16)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .test_mode_i (test_mode_i),
    .clear_i     (clear_i),
    .tcdm        (tcdm),
    .stream      (stream),
    .ctrl_i      (ctrl_i),
    .flags_o     (flags_o)
  );

  int n_tests, n_fail, cyc;
  logic [31:0] bd [16];
  logic [3:0]  bs [16];
  int n_beats, beat_idx, accepted;
  logic [31:0] wr_addr [16];
  logic [31:0] wr_data [16];
  logic [3:0]  wr_be [16];
  int n_wr, done_cnt, done_cyc, last_gnt_cyc, start_cyc;
  int stall_idx, stall_left, clear_at, mid_start_cyc;
  bit in_stall, saw_ready_low, clear_chk, pend_start;
  logic [31:0] st_add, st_data;
  logic [3:0]  st_be;
  logic [31:0] s_base, s_stride;
  logic [15:0] s_len;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clr_log();
    n_wr = 0; done_cnt = 0; done_cyc = -1; last_gnt_cyc = -1; start_cyc = -1;
    beat_idx = 0; accepted = 0; stall_idx = -1; stall_left = 0; in_stall = 0;
    saw_ready_low = 0; clear_at = -1; mid_start_cyc = -1;
  endtask

  task automatic load_beats(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      bd[i] = base + 32'(i);
      bs[i] = 4'hF;
    end
    n_beats = n;
  endtask

  task automatic start(input logic [31:0] base, input logic [31:0] stride, input logic [15:0] len);
    s_base = base; s_stride = stride; s_len = len; pend_start = 1;
  endtask

  // One clock cycle: check post-edge state, drive inputs, log the handshakes of the next edge.
  task automatic tick();
    bit do_clear, stalling;
    @(negedge clk_i);
    if (clear_chk) begin
      check_val("clr_ready_start", flags_o.ready_start, 1'b1);
      check_val("clr_busy", flags_o.busy, 1'b0);
      check_val("clr_req", tcdm.req, 1'b0);
      check_val("clr_out_cnt", flags_o.out_cnt, 16'd0);
      clear_chk = 0;
    end
    ctrl_i.req_start = 1'b0;
    if (pend_start) begin
      ctrl_i.req_start = 1'b1;
      ctrl_i.base_addr = s_base;
      ctrl_i.stride    = s_stride;
      ctrl_i.tot_len   = s_len;
      pend_start = 0;
      start_cyc = cyc;
    end else if (cyc == mid_start_cyc) begin
      ctrl_i.req_start = 1'b1;
      ctrl_i.base_addr = 32'hDEAD_0000;
      ctrl_i.stride    = 32'h100;
      ctrl_i.tot_len   = 16'd1;
    end
    stream.valid = (beat_idx < n_beats);
    stream.data  = (beat_idx < n_beats) ? bd[beat_idx] : 32'h0;
    stream.strb  = (beat_idx < n_beats) ? bs[beat_idx] : 4'h0;
    do_clear = (clear_at >= 0) && (n_wr == clear_at);
    clear_i = do_clear;
    if (do_clear) begin
      clear_at = -1;
      clear_chk = 1;
    end
    stalling = tcdm.req && (n_wr == stall_idx) && (stall_left > 0);
    tcdm.gnt = !(stalling || do_clear);
    if (stalling) begin
      if (!in_stall) begin
        in_stall = 1;
        st_add = tcdm.add; st_data = tcdm.data; st_be = tcdm.be;
      end else begin
        check_val("stall_add", tcdm.add, st_add);
        check_val("stall_data", tcdm.data, st_data);
        check_val("stall_be", tcdm.be, st_be);
      end
      stall_left--;
    end
    #1;
    if (stalling && stream.valid && !stream.ready) saw_ready_low = 1;
    if (stream.valid && stream.ready) begin
      beat_idx++;
      accepted++;
    end
    if (tcdm.req && tcdm.gnt) begin
      check_val("wen", tcdm.wen, 1'b0);
      if (n_wr < 16) begin
        wr_addr[n_wr] = tcdm.add;
        wr_data[n_wr] = tcdm.data;
        wr_be[n_wr]   = tcdm.be;
      end
      n_wr++;
      last_gnt_cyc = cyc;
    end
    if (flags_o.done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    cyc++;
  endtask

  task automatic check_writes(input string tag, input logic [31:0] base, input logic [31:0] stride,
                              input logic [31:0] dbase, input int n);
    check_val({tag, "_n_wr"}, 64'(n_wr), 64'(n));
    for (int i = 0; i < n && i < 16; i++) begin
      check_val($sformatf("%s_addr%0d", tag, i), wr_addr[i], base + stride * 32'(i));
      check_val($sformatf("%s_data%0d", tag, i), wr_data[i], dbase + 32'(i));
    end
  endtask

  initial begin
    n_tests = 0; n_fail = 0; cyc = 0; n_beats = 0;
    pend_start = 0; clear_chk = 0;
    ctrl_i = '0;
    tcdm.gnt = 1'b0; tcdm.r_valid = 1'b0; tcdm.r_data = '0;
    stream.valid = 1'b0; stream.data = '0; stream.strb = '0;
    clr_log();

    repeat (3) @(negedge clk_i);
    check_val("rst_req", tcdm.req, 1'b0);
    check_val("rst_ready", stream.ready, 1'b0);
    check_val("rst_ready_start", flags_o.ready_start, 1'b1);
    check_val("rst_done", flags_o.done, 1'b0);
    check_val("rst_busy", flags_o.busy, 1'b0);
    check_val("rst_out_cnt", flags_o.out_cnt, 16'd0);
    rst_ni = 1'b1;
    repeat (2) tick();

    // 1: basic write
    clr_log(); load_beats(32'hA0, 4); start(32'h1000, 32'd4, 16'd4);
    repeat (14) tick();
    check_writes("s1", 32'h1000, 32'd4, 32'hA0, 4);
    for (int i = 0; i < 4; i++) check_val($sformatf("s1_be%0d", i), wr_be[i], 4'hF);
    check_val("s1_done_cnt", 64'(done_cnt), 64'd1);
    check_val("s1_done_lat", 64'(done_cyc), 64'(last_gnt_cyc + 1));
    check_val("s1_out_cnt", flags_o.out_cnt, 16'd4);

    // 2: grant stalls on the second request
    clr_log(); load_beats(32'hA0, 4); start(32'h1000, 32'd4, 16'd4);
    stall_idx = 1; stall_left = 3;
    repeat (18) tick();
    check_writes("s2", 32'h1000, 32'd4, 32'hA0, 4);
    check_val("s2_ready_drop", 64'(saw_ready_low), 64'd1);
    check_val("s2_done_cnt", 64'(done_cnt), 64'd1);
    check_val("s2_out_cnt", flags_o.out_cnt, 16'd4);

    // 3: over-supply
    clr_log(); load_beats(32'h50, 5); start(32'h2000, 32'd4, 16'd3);
    repeat (14) tick();
    check_val("s3_accepted", 64'(accepted), 64'd3);
    check_val("s3_beat_idx", 64'(beat_idx), 64'd3);
    check_writes("s3", 32'h2000, 32'd4, 32'h50, 3);
    check_val("s3_ready_after", stream.ready, 1'b0);

    // 4: zero length, then address wrap
    clr_log(); load_beats(32'h70, 2); start(32'h4000, 32'd4, 16'd0);
    repeat (5) tick();
    check_val("s4_zero_n_wr", 64'(n_wr), 64'd0);
    check_val("s4_zero_accepted", 64'(accepted), 64'd0);
    check_val("s4_zero_done_cnt", 64'(done_cnt), 64'd1);
    check_val("s4_zero_done_lat", 64'(done_cyc), 64'(start_cyc + 1));
    clr_log(); load_beats(32'h11, 2); start(32'hFFFF_FFF8, 32'd8, 16'd2);
    repeat (10) tick();
    check_val("s4_wrap_addr0", wr_addr[0], 32'hFFFF_FFF8);
    check_val("s4_wrap_addr1", wr_addr[1], 32'h0000_0000);
    check_val("s4_wrap_n_wr", 64'(n_wr), 64'd2);

    // 5: clear after three grants, then a fresh transfer
    clr_log(); load_beats(32'hB0, 8); start(32'h1000, 32'd4, 16'd8);
    clear_at = 3;
    repeat (12) tick();
    clear_i = 1'b0;
    check_val("s5_n_wr", 64'(n_wr), 64'd3);
    check_val("s5_no_done", 64'(done_cnt), 64'd0);
    check_val("s5_clear_taken", 64'(clear_chk), 64'd0);
    clr_log(); load_beats(32'hC0, 2); start(32'h3000, 32'h10, 16'd2);
    repeat (10) tick();
    check_writes("s5b", 32'h3000, 32'h10, 32'hC0, 2);
    check_val("s5b_done_cnt", 64'(done_cnt), 64'd1);

    // 6: partial strobe and a start pulse while busy
    clr_log(); load_beats(32'hD0, 4); bs[1] = 4'h3;
    start(32'h2000, 32'd4, 16'd4);
    mid_start_cyc = cyc + 3;
    repeat (14) tick();
    check_writes("s6", 32'h2000, 32'd4, 32'hD0, 4);
    check_val("s6_be0", wr_be[0], 4'hF);
    check_val("s6_be1", wr_be[1], 4'h3);
    check_val("s6_be2", wr_be[2], 4'hF);
    check_val("s6_out_cnt", flags_o.out_cnt, 16'd4);
    check_val("s6_done_cnt", 64'(done_cnt), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
